pss_peak_detector: RTL and testbench
====================================

Name: pss_peak_detector

Overview:
Consumes the unsigned correlation-magnitude stream produced by the PSS correlator and detects PSS peaks against an adaptive noise-floor threshold. A moving average of recent non-peak samples sets the threshold. Once the threshold is exceeded, the block searches a fixed window for the maximum and reports its value and sample index as a one-cycle pulse. Sits directly downstream of the correlator and feeds the timing/SSB-sync logic.

Parameters:
IN_DW, 32, width of the correlator magnitude input (unsigned)
WINDOW_LEN, 16, noise-floor averaging length in samples; power of 2, >= 2
DETECTION_SHIFT, 3, threshold = average << DETECTION_SHIFT
SEARCH_LEN, 8, samples examined per detection, including the trigger sample; >= 1
HOLDOFF_LEN, 64, samples ignored after a detection; >= 0
CNT_DW, 32, width of the sample index counter

Ports:
clk_i  input  1  clock
reset_ni  input  1  reset; asynchronous, active-low
s_axis_in_tdata  input  IN_DW  correlation magnitude, unsigned
s_axis_in_tvalid  input  1  sample valid; no backpressure, every valid sample is consumed
peak_detected_o  output  1  one-cycle pulse when a peak is reported
peak_value_o  output  IN_DW  magnitude of the reported peak; held until the next report
peak_index_o  output  CNT_DW  sample index of the reported peak; held until the next report
noise_floor_o  output  IN_DW  current average, sum >> log2(WINDOW_LEN)
state_o  output  2  current state: 0 WARMUP, 1 IDLE, 2 SEARCH, 3 HOLDOFF

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While reset_ni=0, all outputs, the history buffer, running sum, all counters and the state are 0 (WARMUP).
- Sample index: sample_cnt starts at 0 after reset and increments by 1 for every valid sample. It wraps modulo 2^CNT_DW. The index of a sample is sample_cnt at the time it is accepted.
- Noise floor:
  - History is a WINDOW_LEN-deep shift register with a running sum of width IN_DW+log2(WINDOW_LEN).
  - sum_next = sum + new - oldest. No truncation is allowed.
  - History and sum update only for samples accepted in WARMUP or IDLE. They are frozen in SEARCH and HOLDOFF.
  - The threshold applied to a sample uses the average of previously accepted samples, never the current one.
  - The threshold width is IN_DW+DETECTION_SHIFT. The comparison is unsigned.
- States (all transitions occur only on valid samples):
  - WARMUP: count accepted samples. The WINDOW_LEN-th sample moves the state to IDLE. No detection in WARMUP, including that sample.
  - IDLE: if sample > threshold (strict), go to SEARCH. Load max=sample, max_idx=index, search_cnt=1. The trigger sample is not written into history. Otherwise push the sample into history.
  - SEARCH: if sample > max (strict), update max/max_idx; ties keep the earliest. Increment search_cnt.
  - SEARCH exit: when search_cnt reaches SEARCH_LEN, including the sample just accepted, register peak_value_o/peak_index_o and pulse peak_detected_o on the next clock edge. Then go to HOLDOFF, or to IDLE if HOLDOFF_LEN=0.
  - SEARCH_LEN=1: the report follows the trigger sample directly.
  - HOLDOFF: discard HOLDOFF_LEN valid samples (index still counts), then go to IDLE.
- Latency: peak_detected_o is asserted in the cycle after the clock edge that accepted the last search sample. It is exactly one cycle wide.
- tvalid gaps: the state, counters and search window pause. Results are identical to a gap-free stream.
- Reset mid-SEARCH: no pulse is produced. Operation restarts in WARMUP with index 0.
- Index wrap during SEARCH: the reported index is the wrapped value.

Test Plan:
- Basic peak (defaults): indices 0-15 = 100 (floor 100, threshold 800); idx 20 = 900, idx 22 = 5000; all others 100. Required: one pulse the cycle after idx 27 is accepted; value 5000, index 22; noise_floor_o stays 100.
- Tie and first-sample max: idx 20 = 5000, idx 24 = 5000, others 100. Required: value 5000, index 20.
- Warm-up and threshold edge: idx 10 = 50000 gives no pulse. After warm-up on 100s, a sample of exactly 800 gives no trigger and enters history; 801 triggers SEARCH.
- Holdoff: peaks at idx 20 and idx 60 (=5000). Required: only idx 20 is reported. A peak at idx 20+8+64 = 92 is reported as index 92.
- Randomised tvalid gaps (about 50% duty) on the basic-peak stream. Required: the same single report (5000, 22).
- Async reset asserted at idx 24 mid-SEARCH. Required: outputs 0 immediately, no pulse, state_o=0. After release, the index restarts at 0 and a repeat of the basic stream reproduces (5000, 22).

Source files
------------

// File: rtl/pss_peak_detector.sv
// PSS peak detector: adaptive noise-floor threshold from a moving average of
// non-peak samples, fixed-length maximum search, then holdoff.
module pss_peak_detector #(
  parameter int IN_DW           = 32,
  parameter int WINDOW_LEN      = 16,
  parameter int DETECTION_SHIFT = 3,
  parameter int SEARCH_LEN      = 8,
  parameter int HOLDOFF_LEN     = 64,
  parameter int CNT_DW          = 32
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [IN_DW-1:0]  s_axis_in_tdata,
  input  logic              s_axis_in_tvalid,
  output logic              peak_detected_o,
  output logic [IN_DW-1:0]  peak_value_o,
  output logic [CNT_DW-1:0] peak_index_o,
  output logic [IN_DW-1:0]  noise_floor_o,
  output logic [1:0]        state_o
);

  localparam int LOG2_W = $clog2(WINDOW_LEN);
  localparam int SUM_DW = IN_DW + LOG2_W;
  localparam int THR_DW = IN_DW + DETECTION_SHIFT;
  localparam int WC_DW  = $clog2(WINDOW_LEN + 1);
  localparam int SC_DW  = $clog2(SEARCH_LEN + 1);
  localparam int HC_DW  = (HOLDOFF_LEN > 0) ? $clog2(HOLDOFF_LEN + 1) : 1;

  localparam logic [WC_DW-1:0] WARM_LAST   = WC_DW'(WINDOW_LEN - 1);
  localparam logic [SC_DW-1:0] SEARCH_LAST = SC_DW'(SEARCH_LEN - 1);
  localparam logic [HC_DW-1:0] HOLD_LAST   = HC_DW'((HOLDOFF_LEN > 0) ? HOLDOFF_LEN - 1 : 0);

  localparam logic [1:0] ST_WARMUP  = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_SEARCH  = 2'd2;
  localparam logic [1:0] ST_HOLDOFF = 2'd3;

  logic [IN_DW-1:0]  hist_q [WINDOW_LEN];
  logic [IN_DW-1:0]  hist_d [WINDOW_LEN];
  logic [SUM_DW-1:0] sum_q, sum_d;
  logic [CNT_DW-1:0] sample_cnt_q, sample_cnt_d;
  logic [WC_DW-1:0]  warm_cnt_q, warm_cnt_d;
  logic [SC_DW-1:0]  search_cnt_q, search_cnt_d;
  logic [HC_DW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [IN_DW-1:0]  max_q, max_d;
  logic [CNT_DW-1:0] max_idx_q, max_idx_d;
  logic [1:0]        state_q, state_d;
  logic              peak_detected_q, peak_detected_d;
  logic [IN_DW-1:0]  peak_value_q, peak_value_d;
  logic [CNT_DW-1:0] peak_index_q, peak_index_d;

  logic [IN_DW-1:0]  avg;
  logic [THR_DW-1:0] threshold;
  logic              push;
  logic              report;

  // The average comes from the registered sum, so the current sample never
  // contributes to its own threshold.
  assign avg       = IN_DW'(sum_q >> LOG2_W);
  assign threshold = THR_DW'(avg) << DETECTION_SHIFT;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    hist_d          = hist_q;
    sum_d           = sum_q;
    sample_cnt_d    = sample_cnt_q;
    warm_cnt_d      = warm_cnt_q;
    search_cnt_d    = search_cnt_q;
    hold_cnt_d      = hold_cnt_q;
    max_d           = max_q;
    max_idx_d       = max_idx_q;
    state_d         = state_q;
    peak_detected_d = 1'b0;
    peak_value_d    = peak_value_q;
    peak_index_d    = peak_index_q;
    push            = 1'b0;
    report          = 1'b0;

    if (s_axis_in_tvalid) begin
      sample_cnt_d = sample_cnt_q + CNT_DW'(1);
      case (state_q)
        ST_WARMUP: begin
          push       = 1'b1;
          warm_cnt_d = warm_cnt_q + WC_DW'(1);
          if (warm_cnt_q == WARM_LAST) state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (THR_DW'(s_axis_in_tdata) > threshold) begin
            state_d      = ST_SEARCH;
            max_d        = s_axis_in_tdata;
            max_idx_d    = sample_cnt_q;
            search_cnt_d = SC_DW'(1);
            report       = (SEARCH_LEN == 1);
          end else begin
            push = 1'b1;
          end
        end
        ST_SEARCH: begin
          if (s_axis_in_tdata > max_q) begin
            max_d     = s_axis_in_tdata;
            max_idx_d = sample_cnt_q;
          end
          search_cnt_d = search_cnt_q + SC_DW'(1);
          report       = (search_cnt_q == SEARCH_LAST);
        end
        default: begin
          hold_cnt_d = hold_cnt_q + HC_DW'(1);
          if (hold_cnt_q == HOLD_LAST) state_d = ST_IDLE;
        end
      endcase
    end

    if (report) begin
      peak_detected_d = 1'b1;
      peak_value_d    = max_d;
      peak_index_d    = max_idx_d;
      hold_cnt_d      = '0;
      state_d         = (HOLDOFF_LEN == 0) ? ST_IDLE : ST_HOLDOFF;
    end

    if (push) begin
      hist_d[0] = s_axis_in_tdata;
      for (int i = 1; i < WINDOW_LEN; i++) hist_d[i] = hist_q[i-1];
      sum_d = sum_q + SUM_DW'(s_axis_in_tdata) - SUM_DW'(hist_q[WINDOW_LEN-1]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      // NOTE: the history is reset too; the running sum relies on the
      // evicted entries being zero throughout warm-up.
      for (int i = 0; i < WINDOW_LEN; i++) hist_q[i] <= '0;
      sum_q           <= '0;
      sample_cnt_q    <= '0;
      warm_cnt_q      <= '0;
      search_cnt_q    <= '0;
      hold_cnt_q      <= '0;
      max_q           <= '0;
      max_idx_q       <= '0;
      state_q         <= ST_WARMUP;
      peak_detected_q <= 1'b0;
      peak_value_q    <= '0;
      peak_index_q    <= '0;
    end else begin
      hist_q          <= hist_d;
      sum_q           <= sum_d;
      sample_cnt_q    <= sample_cnt_d;
      warm_cnt_q      <= warm_cnt_d;
      search_cnt_q    <= search_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      max_q           <= max_d;
      max_idx_q       <= max_idx_d;
      state_q         <= state_d;
      peak_detected_q <= peak_detected_d;
      peak_value_q    <= peak_value_d;
      peak_index_q    <= peak_index_d;
    end
  end

  assign peak_detected_o = peak_detected_q;
  assign peak_value_o    = peak_value_q;
  assign peak_index_o    = peak_index_q;
  assign noise_floor_o   = avg;
  assign state_o         = state_q;

endmodule

// File: tb/tb_pss_peak_detector.sv
// Self-checking bench for pss_peak_detector: directed streams plus random
// traffic, all compared cycle by cycle against a queue-based reference model.
module tb_pss_peak_detector;

  localparam int IN_DW = 32, WINDOW_LEN = 16, DETECTION_SHIFT = 3;
  localparam int SEARCH_LEN = 8, HOLDOFF_LEN = 64, CNT_DW = 32;

  logic              clk_i = 1'b0;
  logic              reset_ni = 1'b0;
  logic [IN_DW-1:0]  s_axis_in_tdata = '0;
  logic              s_axis_in_tvalid = 1'b0;
  logic              peak_detected_o;
  logic [IN_DW-1:0]  peak_value_o;
  logic [CNT_DW-1:0] peak_index_o;
  logic [IN_DW-1:0]  noise_floor_o;
  logic [1:0]        state_o;

  pss_peak_detector #(
    .IN_DW(IN_DW), .WINDOW_LEN(WINDOW_LEN), .DETECTION_SHIFT(DETECTION_SHIFT),
    .SEARCH_LEN(SEARCH_LEN), .HOLDOFF_LEN(HOLDOFF_LEN), .CNT_DW(CNT_DW)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .s_axis_in_tdata(s_axis_in_tdata), .s_axis_in_tvalid(s_axis_in_tvalid),
    .peak_detected_o(peak_detected_o), .peak_value_o(peak_value_o),
    .peak_index_o(peak_index_o), .noise_floor_o(noise_floor_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: history as a queue of the last WINDOW_LEN non-peak samples.
  int unsigned   m_hist[$];
  int            m_mode;      // 0 warmup, 1 idle, 2 search, 3 holdoff
  bit [31:0]     m_cnt;
  int            m_seen, m_hold;
  int unsigned   m_max;
  bit [31:0]     m_max_idx;
  bit            m_pulse;
  int unsigned   m_val;
  bit [31:0]     m_idx;

  function automatic int unsigned m_floor();
    longint unsigned s = 0;
    foreach (m_hist[i]) s += m_hist[i];
    return int'(s / WINDOW_LEN);
  endfunction

  task automatic m_reset();
    m_hist.delete();
    m_mode = 0; m_cnt = 0; m_seen = 0; m_hold = 0;
    m_max = 0; m_max_idx = 0; m_pulse = 0; m_val = 0; m_idx = 0;
  endtask

  task automatic m_push(input int unsigned d);
    m_hist.push_back(d);
    if (m_hist.size() > WINDOW_LEN) void'(m_hist.pop_front());
  endtask

  task automatic m_step(input bit v, input int unsigned d);
    bit [31:0] idx;
    longint unsigned thr;
    m_pulse = 0;
    if (!v) return;
    idx = m_cnt;
    m_cnt = m_cnt + 1;
    thr = longint'(m_floor()) << DETECTION_SHIFT;
    case (m_mode)
      0: begin
        m_push(d);
        if (m_hist.size() == WINDOW_LEN) m_mode = 1;
      end
      1: begin
        if (longint'(d) > thr) begin
          m_mode = 2; m_max = d; m_max_idx = idx; m_seen = 1;
        end else m_push(d);
      end
      2: begin
        if (d > m_max) begin m_max = d; m_max_idx = idx; end
        m_seen++;
      end
      default: begin
        m_hold++;
        if (m_hold == HOLDOFF_LEN) m_mode = 1;
      end
    endcase
    if (m_mode == 2 && m_seen == SEARCH_LEN) begin
      m_pulse = 1; m_val = m_max; m_idx = m_max_idx; m_hold = 0;
      m_mode = (HOLDOFF_LEN == 0) ? 1 : 3;
    end
  endtask

  // Observed report tracking for directed expectations.
  int          n_pulse;
  logic [31:0] last_val, last_idx;

  task automatic compare_all();
    check("pulse", peak_detected_o, m_pulse);
    check("value", peak_value_o, m_val);
    check("index", peak_index_o, m_idx);
    check("floor", noise_floor_o, m_floor());
    check("state", state_o, m_mode);
    if (peak_detected_o) begin
      n_pulse++; last_val = peak_value_o; last_idx = peak_index_o;
    end
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic send(input bit v, input int unsigned d);
    s_axis_in_tvalid = v;
    s_axis_in_tdata  = d;
    @(posedge clk_i);
    m_step(v, d);
    @(negedge clk_i);
    compare_all();
  endtask

  int          sp_idx[$];
  int unsigned sp_val[$];

  function automatic int unsigned val_at(input int i);
    foreach (sp_idx[k]) if (sp_idx[k] == i) return sp_val[k];
    return 100;
  endfunction

  task automatic run_stream(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) send(1'b0, $urandom);
      send(1'b1, val_at(i));
    end
    s_axis_in_tvalid = 1'b0;
  endtask

  // Called at a negedge; asserts reset asynchronously and checks outputs at once.
  task automatic do_reset();
    #2 reset_ni = 1'b0;
    #1;
    m_reset();
    check("rst_pulse", peak_detected_o, 1'b0);
    check("rst_value", peak_value_o, 0);
    check("rst_index", peak_index_o, 0);
    check("rst_floor", noise_floor_o, 0);
    check("rst_state", state_o, 0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    @(negedge clk_i);
    n_pulse = 0; last_val = '0; last_idx = '0;
  endtask

  task automatic set_spikes(input int a, input int unsigned av, input int b, input int unsigned bv);
    sp_idx.delete(); sp_val.delete();
    sp_idx.push_back(a); sp_val.push_back(av);
    if (b >= 0) begin sp_idx.push_back(b); sp_val.push_back(bv); end
  endtask

  initial begin
    m_reset();
    @(negedge clk_i);

    // Basic peak.
    do_reset();
    set_spikes(20, 900, 22, 5000);
    run_stream(40, 1'b0);
    check("basic_count", n_pulse, 1);
    check("basic_value", last_val, 5000);
    check("basic_index", last_idx, 22);
    check("basic_floor", noise_floor_o, 100);

    // Tie keeps the earliest sample, which is the trigger itself.
    do_reset();
    set_spikes(20, 5000, 24, 5000);
    run_stream(40, 1'b0);
    check("tie_count", n_pulse, 1);
    check("tie_value", last_val, 5000);
    check("tie_index", last_idx, 20);

    // No detection during warm-up.
    do_reset();
    set_spikes(10, 50000, -1, 0);
    run_stream(30, 1'b0);
    check("warm_count", n_pulse, 0);

    // Exactly the threshold: no trigger, sample enters history.
    do_reset();
    set_spikes(16, 800, -1, 0);
    run_stream(17, 1'b0);
    check("thr800_state", state_o, 1);
    check("thr800_floor", noise_floor_o, (15 * 100 + 800) / 16);
    run_stream(13, 1'b0);
    check("thr800_count", n_pulse, 0);

    // One above the threshold triggers.
    do_reset();
    set_spikes(16, 801, -1, 0);
    run_stream(17, 1'b0);
    check("thr801_state", state_o, 2);
    run_stream(13, 1'b0);
    check("thr801_count", n_pulse, 1);
    check("thr801_value", last_val, 801);
    check("thr801_index", last_idx, 16);

    // Holdoff hides the second peak.
    do_reset();
    set_spikes(20, 5000, 60, 5000);
    run_stream(100, 1'b0);
    check("hold_count", n_pulse, 1);
    check("hold_index", last_idx, 20);

    // First sample after holdoff is eligible again.
    do_reset();
    set_spikes(20, 5000, 92, 5000);
    run_stream(110, 1'b0);
    check("post_hold_count", n_pulse, 2);
    check("post_hold_value", last_val, 5000);
    check("post_hold_index", last_idx, 92);

    // Random tvalid gaps.
    do_reset();
    set_spikes(20, 900, 22, 5000);
    run_stream(40, 1'b1);
    check("gap_count", n_pulse, 1);
    check("gap_value", last_val, 5000);
    check("gap_index", last_idx, 22);

    // Reset in the middle of a search.
    do_reset();
    set_spikes(20, 900, 22, 5000);
    run_stream(25, 1'b0);
    check("mid_state", state_o, 2);
    check("mid_count", n_pulse, 0);
    do_reset();
    run_stream(1, 1'b0);
    check("restart_cnt", dut.sample_cnt_q, 1);
    do_reset();
    run_stream(40, 1'b0);
    check("restart_count", n_pulse, 1);
    check("restart_value", last_val, 5000);
    check("restart_index", last_idx, 22);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int unsigned d;
      int r = $urandom_range(0, 99);
      if (r < 2) d = $urandom;
      else if (r < 6) d = $urandom_range(0, 20000);
      else d = $urandom_range(50, 150);
      send($urandom_range(0, 9) < 7, d);
    end
    s_axis_in_tvalid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
